// File: rtl/cpu_trace_emitter.sv
// Serialises one retired-instruction record per handshake into an ASCII trace line,
// one character per clock: "^TIME@PC: $GRF <= DATA#" or "^TIME@PC: *ADDR <= DATA#".
module cpu_trace_emitter #(
  parameter logic [7:0]  IDLE_CHAR = 8'h0A,
  parameter int unsigned TIME_MAX  = 9999
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_type,
  input  logic [13:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_grf,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  char,
  output logic        char_valid,
  output logic        line_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_TAG,
    S_GRF, S_ADDR, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
  } state_t;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [7:0]  r_char;
  logic        r_char_valid;
  logic        r_line_done;

  logic        r_type;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [3:0][3:0] r_tdig;
  logic [1:0]  r_tstart;
  logic [1:0][3:0] r_gdig;
  logic        r_gstart;

  logic        w_accept;
  logic [13:0] w_time_cl;
  logic [2:0]  w_idx_dn;

  assign in_ready   = !reset && (r_state == S_IDLE || r_state == S_HASH);
  assign w_accept   = in_valid && in_ready;
  assign w_time_cl  = (in_time > 14'(TIME_MAX)) ? 14'(TIME_MAX) : in_time;
  assign w_idx_dn   = r_idx - 3'd1;
  assign char       = r_char;
  assign char_valid = r_char_valid;
  assign line_done  = r_line_done;

  function automatic logic [7:0] dec_char(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h57 + {4'h0, d});
  endfunction

  function automatic logic [7:0] nib_char(input logic [31:0] w, input logic [2:0] i);
    return hex_char(w[{i, 2'b00} +: 4]);
  endfunction

  // Record capture with digits precomputed; index stored is (digit count - 1), counted down to 0.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_type    <= in_type;
      r_pc      <= in_pc;
      r_addr    <= in_addr;
      r_data    <= in_data;
      r_tdig[3] <= 4'(w_time_cl / 14'd1000);
      r_tdig[2] <= 4'((w_time_cl / 14'd100) % 14'd10);
      r_tdig[1] <= 4'((w_time_cl / 14'd10) % 14'd10);
      r_tdig[0] <= 4'(w_time_cl % 14'd10);
      r_tstart  <= (w_time_cl >= 14'd1000) ? 2'd3 :
                   (w_time_cl >= 14'd100)  ? 2'd2 :
                   (w_time_cl >= 14'd10)   ? 2'd1 : 2'd0;
      r_gdig[1] <= 4'(in_grf / 5'd10);
      r_gdig[0] <= 4'(in_grf % 5'd10);
      r_gstart  <= (in_grf >= 5'd10);
    end
  end

  // Line sequencer: the registered char always belongs to the current state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= 3'd0;
      r_char       <= IDLE_CHAR;
      r_char_valid <= 1'b0;
      r_line_done  <= 1'b0;
    end else begin
      r_char_valid <= 1'b1;
      r_line_done  <= 1'b0;
      case (r_state)
        S_IDLE, S_HASH: begin
          if (w_accept) begin
            r_state <= S_CARET;
            r_char  <= 8'h5E;
          end else begin
            r_state      <= S_IDLE;
            r_char       <= IDLE_CHAR;
            r_char_valid <= 1'b0;
          end
        end
        S_CARET: begin
          r_state <= S_TIME;
          r_idx   <= {1'b0, r_tstart};
          r_char  <= dec_char(r_tdig[r_tstart]);
        end
        S_TIME: begin
          if (r_idx == 3'd0) begin
            r_state <= S_AT;
            r_char  <= 8'h40;
          end else begin
            r_idx  <= w_idx_dn;
            r_char <= dec_char(r_tdig[w_idx_dn[1:0]]);
          end
        end
        S_AT: begin
          r_state <= S_PC;
          r_idx   <= 3'd7;
          r_char  <= nib_char(r_pc, 3'd7);
        end
        S_PC: begin
          if (r_idx == 3'd0) begin
            r_state <= S_COLON;
            r_char  <= 8'h3A;
          end else begin
            r_idx  <= w_idx_dn;
            r_char <= nib_char(r_pc, w_idx_dn);
          end
        end
        S_COLON: begin
          r_state <= S_SP1;
          r_char  <= 8'h20;
        end
        S_SP1: begin
          r_state <= S_TAG;
          r_char  <= r_type ? 8'h2A : 8'h24;
        end
        S_TAG: begin
          if (r_type) begin
            r_state <= S_ADDR;
            r_idx   <= 3'd7;
            r_char  <= nib_char(r_addr, 3'd7);
          end else begin
            r_state <= S_GRF;
            r_idx   <= {2'b00, r_gstart};
            r_char  <= dec_char(r_gdig[r_gstart]);
          end
        end
        S_GRF: begin
          if (r_idx == 3'd0) begin
            r_state <= S_SP2;
            r_char  <= 8'h20;
          end else begin
            r_idx  <= w_idx_dn;
            r_char <= dec_char(r_gdig[w_idx_dn[0]]);
          end
        end
        S_ADDR: begin
          if (r_idx == 3'd0) begin
            r_state <= S_SP2;
            r_char  <= 8'h20;
          end else begin
            r_idx  <= w_idx_dn;
            r_char <= nib_char(r_addr, w_idx_dn);
          end
        end
        S_SP2: begin
          r_state <= S_LT;
          r_char  <= 8'h3C;
        end
        S_LT: begin
          r_state <= S_EQ;
          r_char  <= 8'h3D;
        end
        S_EQ: begin
          r_state <= S_SP3;
          r_char  <= 8'h20;
        end
        S_SP3: begin
          r_state <= S_DATA;
          r_idx   <= 3'd7;
          r_char  <= nib_char(r_data, 3'd7);
        end
        S_DATA: begin
          if (r_idx == 3'd0) begin
            r_state     <= S_HASH;
            r_char      <= 8'h23;
            r_line_done <= 1'b1;
          end else begin
            r_idx  <= w_idx_dn;
            r_char <= nib_char(r_data, w_idx_dn);
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_char       <= IDLE_CHAR;
          r_char_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Bench for cpu_trace_emitter: directed and random records, each expected line
// built as a formatted string and compared character by character.
module tb_cpu_trace_emitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_type;
  logic [13:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_grf;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [7:0]  char;
  logic        char_valid;
  logic        line_done;

  int n_chk = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  cpu_trace_emitter dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_time(in_time), .in_pc(in_pc),
    .in_grf(in_grf), .in_addr(in_addr), .in_data(in_data),
    .char(char), .char_valid(char_valid), .line_done(line_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the whole line as text, with time clamped to 9999.
  function automatic string line_of(input logic typ, input logic [13:0] t,
                                    input logic [31:0] pc, input logic [4:0] grf,
                                    input logic [31:0] addr, input logic [31:0] data);
    int tc;
    tc = (int'(t) > 9999) ? 9999 : int'(t);
    if (typ) return $sformatf("^%0d@%08x: *%08x <= %08x#", tc, pc, addr, data);
    else     return $sformatf("^%0d@%08x: $%0d <= %08x#", tc, pc, grf, data);
  endfunction

  // Scoreboard: one expected character per cycle while a line is owed, idle otherwise.
  always @(negedge clk) begin
    logic [7:0] e;
    logic       exp_ready;
    string      s;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("char_valid", 32'(char_valid), 32'd1);
      chk("char", 32'(char), 32'(e));
      chk("line_done", 32'(line_done), 32'(e == 8'h23));
    end else begin
      chk("idle_valid", 32'(char_valid), 32'd0);
      chk("idle_char", 32'(char), 32'h0A);
      chk("idle_done", 32'(line_done), 32'd0);
    end
    exp_ready = !reset && (exp_q.size() == 0);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    if (reset) exp_q.delete();
    else if (in_valid && exp_ready) begin
      s = line_of(in_type, in_time, in_pc, in_grf, in_addr, in_data);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    end
  end

  // Offer a record and return just after the edge that accepts it; in_valid stays high.
  task automatic send(input logic typ, input logic [13:0] t, input logic [31:0] pc,
                      input logic [4:0] grf, input logic [31:0] addr, input logic [31:0] data);
    logic acc;
    int   budget;
    in_valid = 1'b1; in_type = typ; in_time = t; in_pc = pc;
    in_grf = grf; in_addr = addr; in_data = data;
    acc = 1'b0;
    budget = 0;
    while (!acc && budget < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_time  = 14'($urandom);
    in_pc    = $urandom;
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [13:0] rand_time();
    case ($urandom_range(0, 4))
      0:       return 14'($urandom_range(0, 9));
      1:       return 14'($urandom_range(10, 99));
      2:       return 14'($urandom_range(100, 999));
      3:       return 14'($urandom_range(1000, 9999));
      default: return 14'($urandom_range(10000, 16383));
    endcase
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_type = 1'b0; in_time = '0;
    in_pc = '0; in_grf = '0; in_addr = '0; in_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    send(1'b0, 14'd7, 32'h0000_3000, 5'd5, 32'h1234_5678, 32'hdead_beef);
    idle(3);
    send(1'b1, 14'd1234, 32'h0000_3ffc, 5'd17, 32'h0000_0010, 32'h0000_0000);
    idle(2);
    send(1'b0, 14'd12000, 32'hffff_ffff, 5'd31, 32'h0, 32'h89ab_cdef);
    idle(1);
    send(1'b0, 14'd0, 32'h0000_0000, 5'd0, 32'hffff_ffff, 32'h0123_4567);
    idle(1);
    send(1'b1, 14'd16383, 32'habcd_ef01, 5'd9, 32'hfedc_ba98, 32'h7654_3210);
    idle(1);

    // Back-to-back lines with in_valid held high.
    send(1'b0, 14'd42, 32'h0000_3004, 5'd10, 32'h0, 32'h0000_0001);
    send(1'b1, 14'd999, 32'h0000_3008, 5'd3, 32'h0000_00a0, 32'hcafe_f00d);
    send(1'b0, 14'd100, 32'h0000_300c, 5'd29, 32'h0, 32'h0000_ffff);
    idle(3);

    // Reset during the 10th character, then a clean line.
    send(1'b1, 14'd5678, 32'h1111_2222, 5'd1, 32'h3333_4444, 32'h5555_6666);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    idle(1);
    send(1'b0, 14'd88, 32'h0000_4000, 5'd12, 32'h0, 32'hbeef_0000);
    idle(2);

    for (int k = 0; k < 60; k++) begin
      send(1'($urandom), rand_time(), $urandom, 5'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
    end
    idle(45);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cpu_trace_emitter.md
Name: cpu_trace_emitter

Overview:
- Upstream producer for the CPU-output line checker; converts one retired-instruction record per handshake into the ASCII trace line stream the checker parses, one character per clock.
- Register-write line format: "^" TIME "@" PC ": $" GRF " <= " DATA "#".
- Memory-write line format: "^" TIME "@" PC ": *" ADDR " <= " DATA "#".
- Drives the checker's char input directly and gives the bench a golden stimulus source.

Parameters:
IDLE_CHAR, 8'h0A, character driven on char while no line is being emitted
TIME_MAX, 9999, largest printable time; larger inputs clamp to this value

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  record available
in_ready  output  1  record accepted this cycle when in_valid && in_ready
in_type  input  1  0 = register write ($ line), 1 = memory write (* line)
in_time  input  14  decimal time stamp
in_pc  input  32  PC, printed as 8 lowercase hex digits
in_grf  input  5  register number, printed in decimal
in_addr  input  32  memory address, printed as 8 lowercase hex digits
in_data  input  32  written data, printed as 8 lowercase hex digits
char  output  8  current ASCII character
char_valid  output  1  char is part of a line
line_done  output  1  1-cycle pulse, high in the same cycle char == "#"

Behaviour:
- All outputs are registered except in_ready.
- Reset values: char = IDLE_CHAR, char_valid = 0, line_done = 0, FSM in IDLE. The same values apply when reset occurs mid-line. The partial line is abandoned and nothing resumes afterwards.
- in_ready = !reset && (state == IDLE || state == HASH). HASH-state acceptance gives back-to-back lines with no gap character.
- On accept:
  - Latch all fields.
  - Clamp time to TIME_MAX.
  - Precompute decimal digits of time (1-4 digits) and grf (1-2 digits). Leading zeros are suppressed; value 0 prints "0".
- The first character "^" appears on char the cycle after acceptance. Each later cycle emits the next character. There is no output backpressure.
- FSM sequence: IDLE -> CARET -> TIME (td cycles, MSD first) -> AT -> PC (8 cycles, MSN first) -> COLON -> SP1 -> TAG ("$" or "*") -> GRF (gd cycles) or ADDR (8 cycles) -> SP2 -> LT -> EQ -> SP3 -> DATA (8 cycles) -> HASH.
- From HASH: go to CARET if a record is accepted in that cycle, else IDLE.
- Hex digits 10-15 are emitted as "a"-"f". Uppercase is never produced.
- Line length:
  - register line: 26 + td + gd characters.
  - memory line: 34 + td characters.
- char_valid = 1 exactly on line characters.
- In IDLE: char = IDLE_CHAR and char_valid = 0.
- Field latches and digit registers are not cleared by reset; only FSM state and outputs are.
- in_grf and in_addr are both latched on every accept. Only the field selected by in_type is printed.
- A record offered while not ready is ignored; the latched fields stay unchanged.

Test Plan:
- type=0, time=7, pc=0x3000, grf=5, data=0xdeadbeef -> char sequence "^7@00003000: $5 <= deadbeef#" (28 chars), then IDLE_CHAR with char_valid=0; line_done high only on "#".
- type=1, time=1234, pc=0x3ffc, addr=0x10, data=0 -> "^1234@00003ffc: *00000010 <= 00000000#" (38 chars).
- time=12000 (clamp), time=0, grf=31, grf=0 -> "^9999@...", "^0@...", "$31", "$0" respectively.
- in_valid held high with two records -> second "^" directly follows first "#" with no idle cycle; in_ready high exactly in the IDLE and "#" cycles.
- reset asserted on the 10th character of a line -> next cycle char=0x0A, char_valid=0; in_ready=0 during reset; the following record is emitted in full and correctly.
- Chain into the line checker with a random legal record stream -> checker's format_type is nonzero on every "#" cycle and error_code matches a model computed from the records.
